// File: rtl/i2s_tx_xover_pkg.sv
// Shared constants for the crossover I2S transmitter.
package i2s_tx_xover_pkg;

    localparam int unsigned c_I2S_MCK_PER_BCK = 4;
    localparam int unsigned c_I2S_SLOT_BITS   = 32;
    localparam int unsigned c_I2S_DATA_BITS   = 24;
    // One stereo frame in mck cycles (256 with the defaults, i.e. mck = 256*fs).
    localparam int unsigned c_I2S_FRAME_MCK   = 2 * c_I2S_SLOT_BITS * c_I2S_MCK_PER_BCK;

endpackage

// File: rtl/sat_s32_to_s24.sv
// Combinational saturation of a signed 32-bit sample to signed DATA_BITS.
module sat_s32_to_s24
    import i2s_tx_xover_pkg::*;
#(
    parameter int unsigned DATA_BITS = c_I2S_DATA_BITS
) (
    input  logic signed [31:0]          i_din,
    output logic        [DATA_BITS-1:0] o_dout
);

    // Largest and smallest representable DATA_BITS values, sign-extended to 32 bits.
    localparam logic signed [31:0] c_MAX = 32'sh7FFF_FFFF >>> (32 - DATA_BITS);
    localparam logic signed [31:0] c_MIN = ~c_MAX;

    // Clip to the signed range, otherwise keep the low bits unchanged.
    always_comb begin
        o_dout = i_din[DATA_BITS-1:0];
        if (i_din > c_MAX) begin
            o_dout = {1'b0, {(DATA_BITS-1){1'b1}}};
        end else if (i_din < c_MIN) begin
            o_dout = {1'b1, {(DATA_BITS-1){1'b0}}};
        end
    end

endmodule

// File: rtl/i2s_tx_xover.sv
// Stereo I2S transmitter: woofer (LPF) and tweeter (HPF) data lines, self-generated BCK/LRCK.
module i2s_tx_xover
    import i2s_tx_xover_pkg::*;
#(
    parameter int unsigned MCK_PER_BCK = c_I2S_MCK_PER_BCK,
    parameter int unsigned SLOT_BITS   = c_I2S_SLOT_BITS,
    parameter int unsigned DATA_BITS   = c_I2S_DATA_BITS
) (
    input  logic               i_mck,
    input  logic               i_rstn,
    input  logic signed [31:0] i_lpf_l,
    input  logic signed [31:0] i_hpf_l,
    input  logic signed [31:0] i_lpf_r,
    input  logic signed [31:0] i_hpf_r,
    input  logic               i_sample_valid,
    output logic               o_bck,
    output logic               o_lrck,
    output logic               o_sd_lpf,
    output logic               o_sd_hpf,
    output logic               o_frame_start,
    output logic               o_underrun
);

    localparam int unsigned c_FRAME = 2 * SLOT_BITS * MCK_PER_BCK;
    localparam int unsigned c_CNT_W = $clog2(c_FRAME);
    localparam int unsigned c_SR_W  = 2 * SLOT_BITS;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(c_FRAME - 1);

    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [31:0]          w_cnt_ext;
    logic [31:0]          w_phase_nxt;
    logic [31:0]          w_bit_nxt;
    logic                 w_load;
    logic                 w_shift;

    logic [DATA_BITS-1:0] w_sat_lpf_l;
    logic [DATA_BITS-1:0] w_sat_hpf_l;
    logic [DATA_BITS-1:0] w_sat_lpf_r;
    logic [DATA_BITS-1:0] w_sat_hpf_r;

    logic [DATA_BITS-1:0] r_hold_lpf_l;
    logic [DATA_BITS-1:0] r_hold_hpf_l;
    logic [DATA_BITS-1:0] r_hold_lpf_r;
    logic [DATA_BITS-1:0] r_hold_hpf_r;
    logic                 r_new;

    logic [c_SR_W-1:0]    r_sr_lpf;
    logic [c_SR_W-1:0]    r_sr_hpf;
    logic [c_SR_W-1:0]    w_ld_lpf;
    logic [c_SR_W-1:0]    w_ld_hpf;

    logic                 r_bck;
    logic                 r_lrck;
    logic                 r_frame_start;
    logic                 r_underrun;

    // Next counter value and its bit/phase split; registered outputs are decoded from it.
    always_comb begin
        w_load      = (r_cnt == c_CNT_MAX);
        w_cnt_nxt   = w_load ? '0 : r_cnt + 1'b1;
        w_cnt_ext   = 32'(w_cnt_nxt);
        w_phase_nxt = w_cnt_ext % MCK_PER_BCK;
        w_bit_nxt   = w_cnt_ext / MCK_PER_BCK;
        // Data advances at every bit boundary except the frame wrap, which reloads instead.
        w_shift     = (w_phase_nxt == 32'd0) && !w_load;
        // Left word in the upper slot, right word in the lower, each left-justified.
        w_ld_lpf    = (c_SR_W'(r_hold_lpf_l) << (c_SR_W - DATA_BITS))
                    | (c_SR_W'(r_hold_lpf_r) << (SLOT_BITS - DATA_BITS));
        w_ld_hpf    = (c_SR_W'(r_hold_hpf_l) << (c_SR_W - DATA_BITS))
                    | (c_SR_W'(r_hold_hpf_r) << (SLOT_BITS - DATA_BITS));
    end

    sat_s32_to_s24 #(.DATA_BITS(DATA_BITS)) u_sat_lpf_l (.i_din(i_lpf_l), .o_dout(w_sat_lpf_l));
    sat_s32_to_s24 #(.DATA_BITS(DATA_BITS)) u_sat_hpf_l (.i_din(i_hpf_l), .o_dout(w_sat_hpf_l));
    sat_s32_to_s24 #(.DATA_BITS(DATA_BITS)) u_sat_lpf_r (.i_din(i_lpf_r), .o_dout(w_sat_lpf_r));
    sat_s32_to_s24 #(.DATA_BITS(DATA_BITS)) u_sat_hpf_r (.i_din(i_hpf_r), .o_dout(w_sat_hpf_r));

    // Free-running frame counter.
    always_ff @(posedge i_mck or negedge i_rstn) begin
        if (!i_rstn) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // Bit clock, one-BCK-early word select and frame marker, aligned with the counter.
    always_ff @(posedge i_mck or negedge i_rstn) begin
        if (!i_rstn) begin
            r_bck         <= 1'b0;
            r_lrck        <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_bck         <= (w_phase_nxt >= MCK_PER_BCK / 2);
            r_lrck        <= (w_bit_nxt >= SLOT_BITS - 1) && (w_bit_nxt <= 2 * SLOT_BITS - 2);
            r_frame_start <= (w_cnt_nxt == '0);
        end
    end

    // Holding registers; a pulse on the load edge still sets new_flag for the next frame.
    always_ff @(posedge i_mck or negedge i_rstn) begin
        if (!i_rstn) begin
            r_hold_lpf_l <= '0;
            r_hold_hpf_l <= '0;
            r_hold_lpf_r <= '0;
            r_hold_hpf_r <= '0;
            r_new        <= 1'b0;
        end else if (i_sample_valid) begin
            r_hold_lpf_l <= w_sat_lpf_l;
            r_hold_hpf_l <= w_sat_hpf_l;
            r_hold_lpf_r <= w_sat_lpf_r;
            r_hold_hpf_r <= w_sat_hpf_r;
            r_new        <= 1'b1;
        end else if (w_load) begin
            r_new        <= 1'b0;
        end
    end

    // Shifters load at frame wrap (flagging a stale reload) and shift MSB-first otherwise.
    always_ff @(posedge i_mck or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sr_lpf   <= '0;
            r_sr_hpf   <= '0;
            r_underrun <= 1'b0;
        end else if (w_load) begin
            r_sr_lpf   <= w_ld_lpf;
            r_sr_hpf   <= w_ld_hpf;
            r_underrun <= r_underrun | ~r_new;
        end else if (w_shift) begin
            r_sr_lpf   <= r_sr_lpf << 1;
            r_sr_hpf   <= r_sr_hpf << 1;
        end
    end

    assign o_bck         = r_bck;
    assign o_lrck        = r_lrck;
    assign o_frame_start = r_frame_start;
    assign o_underrun    = r_underrun;
    assign o_sd_lpf      = r_sr_lpf[c_SR_W-1];
    assign o_sd_hpf      = r_sr_hpf[c_SR_W-1];

endmodule

// File: tb/tb_i2s_tx_xover.sv
// Self-checking bench for i2s_tx_xover against a frame-level reference model.
module tb_i2s_tx_xover;

    localparam int M    = 4;
    localparam int SLOT = 32;
    localparam int F    = 2 * SLOT * M;

    logic        i_mck;
    logic        i_rstn;
    logic [31:0] i_lpf_l;
    logic [31:0] i_hpf_l;
    logic [31:0] i_lpf_r;
    logic [31:0] i_hpf_r;
    logic        i_sample_valid;
    logic        o_bck;
    logic        o_lrck;
    logic        o_sd_lpf;
    logic        o_sd_hpf;
    logic        o_frame_start;
    logic        o_underrun;

    i2s_tx_xover u_dut (
        .i_mck          (i_mck),
        .i_rstn         (i_rstn),
        .i_lpf_l        (i_lpf_l),
        .i_hpf_l        (i_hpf_l),
        .i_lpf_r        (i_lpf_r),
        .i_hpf_r        (i_hpf_r),
        .i_sample_valid (i_sample_valid),
        .o_bck          (o_bck),
        .o_lrck         (o_lrck),
        .o_sd_lpf       (o_sd_lpf),
        .o_sd_hpf       (o_sd_hpf),
        .o_frame_start  (o_frame_start),
        .o_underrun     (o_underrun)
    );

    initial i_mck = 1'b0;
    always #5 i_mck = ~i_mck;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state. Index: 0 lpf_l, 1 hpf_l, 2 lpf_r, 3 hpf_r.
    int          tc;
    bit          just_rst;
    logic [23:0] m_hold  [4];
    logic [23:0] m_frame [4];
    bit          m_new;
    bit          m_under;
    logic [31:0] da [4];
    logic [31:0] db [4];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] sat24(input logic [31:0] v);
        int s = int'(signed'(v));
        if (s > 8388607) return 24'h7FFFFF;
        if (s < -8388608) return 24'h800000;
        return v[23:0];
    endfunction

    // Expected {bck, lrck, sd_lpf, sd_hpf, frame_start, underrun} while the DUT counter is tc.
    function automatic logic [5:0] exp_outs();
        int p = tc % M;
        int b = tc / M;
        int s;
        logic [23:0] wl;
        logic [23:0] wh;
        logic sl;
        logic sh;
        if (just_rst) return 6'b0;
        if (b < SLOT) begin
            s = b; wl = m_frame[0]; wh = m_frame[1];
        end else begin
            s = b - SLOT; wl = m_frame[2]; wh = m_frame[3];
        end
        sl = (s < 24) ? wl[23 - s] : 1'b0;
        sh = (s < 24) ? wh[23 - s] : 1'b0;
        return {(p >= M / 2), (b >= SLOT - 1 && b <= 2 * SLOT - 2), sl, sh, (tc == 0), m_under};
    endfunction

    function automatic logic [31:0] rnd_data();
        logic [23:0] t;
        case ($urandom_range(0, 2))
            0: return $urandom;
            1: begin
                t = 24'($urandom);
                return {{8{t[23]}}, t};
            end
            default: return 32'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic model_reset();
        tc = 0; just_rst = 1'b1; m_new = 1'b0; m_under = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_hold[k] = '0; m_frame[k] = '0;
        end
    endtask

    // One mck cycle: check outputs mid-cycle, present inputs, advance the model on the edge.
    task automatic cycle(input bit v, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3);
        @(negedge i_mck);
        check_eq($sformatf("outs@cnt%0d", tc),
                 {58'd0, o_bck, o_lrck, o_sd_lpf, o_sd_hpf, o_frame_start, o_underrun},
                 {58'd0, exp_outs()});
        i_sample_valid = v; i_lpf_l = d0; i_hpf_l = d1; i_lpf_r = d2; i_hpf_r = d3;
        @(posedge i_mck);
        if (tc == F - 1) begin
            for (int k = 0; k < 4; k++) m_frame[k] = m_hold[k];
            if (!m_new) m_under = 1'b1;
            m_new = 1'b0;
        end
        if (v) begin
            m_hold[0] = sat24(d0); m_hold[1] = sat24(d1);
            m_hold[2] = sat24(d2); m_hold[3] = sat24(d3);
            m_new = 1'b1;
        end
        tc = (tc + 1) % F;
        just_rst = 1'b0;
        #1;
        i_sample_valid = 1'b0;
    endtask

    task automatic run_frames(input int n, input int k1, input int k2);
        repeat (n * F) begin
            if (tc == k1) cycle(1'b1, da[0], da[1], da[2], da[3]);
            else if (tc == k2) cycle(1'b1, db[0], db[1], db[2], db[3]);
            else cycle(1'b0, '0, '0, '0, '0);
        end
    endtask

    task automatic run_to(input int k);
        while (tc != k) cycle(1'b0, '0, '0, '0, '0);
    endtask

    // Asynchronous reset between clock edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        #1;
        i_rstn = 1'b0;
        #1;
        check_eq("async_rst_outs",
                 {58'd0, o_bck, o_lrck, o_sd_lpf, o_sd_hpf, o_frame_start, o_underrun}, 64'd0);
        model_reset();
        repeat (3) @(posedge i_mck);
        #2;
        i_rstn = 1'b1;
    endtask

    initial begin
        int k1;
        int k2;
        i_rstn = 1'b0; i_sample_valid = 1'b0;
        i_lpf_l = '0; i_hpf_l = '0; i_lpf_r = '0; i_hpf_r = '0;
        model_reset();
        repeat (3) @(posedge i_mck);
        #2;
        i_rstn = 1'b1;

        // Idle after reset: zeros on the data lines, underrun from the first load.
        run_frames(2, -1, -1);
        check_eq("idle_underrun", 64'(o_underrun), 64'd1);

        // Basic transfer, valid at cnt 40 every frame.
        do_reset();
        da[0] = 32'h0012_3456; da[1] = 32'h0; da[2] = 32'hFFED_CBA9; da[3] = 32'h1;
        run_frames(3, 40, -1);
        check_eq("steady_no_underrun", 64'(o_underrun), 64'd0);

        // Saturation cases.
        da[0] = 32'h0100_0000; da[1] = 32'h007F_FFFF; da[2] = 32'hFE00_0000; da[3] = 32'h8000_0000;
        run_frames(2, 40, -1);

        // Valid on the load edge: old data this frame, new data next frame, no underrun.
        do_reset();
        da[0] = 32'h0011_1111; da[1] = 32'h0022_2222; da[2] = 32'h0033_3333; da[3] = 32'h0044_4444;
        db[0] = 32'hFFAA_AAAA; db[1] = 32'h0055_5555; db[2] = 32'h0066_6666; db[3] = 32'hFF99_9999;
        run_frames(1, 40, 255);
        run_frames(1, -1, -1);
        check_eq("load_edge_no_underrun", 64'(o_underrun), 64'd0);
        run_frames(1, -1, -1);
        check_eq("stale_underrun", 64'(o_underrun), 64'd1);

        // Two pulses in one frame: last wins, then a retransmitting frame.
        do_reset();
        run_frames(1, 10, 100);
        run_frames(2, -1, -1);

        // Reset in the middle of shifting live data.
        run_frames(1, 20, -1);
        run_to(137);
        do_reset();
        run_frames(1, -1, -1);

        // Randomized frames: none, one, two pulses, or a pulse on the load edge.
        do_reset();
        for (int f = 0; f < 10; f++) begin
            for (int k = 0; k < 4; k++) begin
                da[k] = rnd_data(); db[k] = rnd_data();
            end
            case ($urandom_range(0, 3))
                0: begin k1 = -1; k2 = -1; end
                1: begin k1 = int'($urandom_range(0, F - 1)); k2 = -1; end
                2: begin k1 = int'($urandom_range(0, 120)); k2 = int'($urandom_range(121, F - 1)); end
                default: begin k1 = int'($urandom_range(0, 200)); k2 = F - 1; end
            endcase
            run_frames(1, k1, k2);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
